// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED bounce sequencer.
// Both the FSM and the write path use these definitions.
package led_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLASH = 2'd2
  } state_t;

  // How the LED pattern register is updated in a given cycle.
  typedef enum logic [2:0] {
    PAT_HOLD   = 3'd0,
    PAT_CLEAR  = 3'd1,
    PAT_BALL   = 3'd2,
    PAT_ALL_ON = 3'd3,
    PAT_TOGGLE = 3'd4
  } pat_op_t;

  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;
  localparam int LED_W = 8;
  localparam logic [LED_W-1:0] PATTERN_ALL_ON = 8'hFF;

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler that produces a one-cycle tick every TICK_DIV enabled cycles.
// The tick is the cycle in which the counter sits at TICK_DIV-1.
module led_tick_gen
#(
  parameter int TICK_DIV = 5_000_000
)
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] COUNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= (count_reg == COUNT_LAST) ? '0 : count_reg + CW'(1);
    end
  end

  assign tick = enable && (count_reg == COUNT_LAST);

endmodule

// File: rtl/led_bounce_sequencer.sv
// Bouncing-ball LED sequencer acting as the only write master of the LED PIO.
// A pattern change is registered, then presented as a single write one cycle later.
module led_bounce_sequencer
  import led_seq_pkg::*;
#(
  parameter int TICK_DIV    = 5_000_000,
  parameter int FLASH_COUNT = 3
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        paddle_l,
  input  logic        paddle_r,
  output logic        busy,
  output logic        miss_l,
  output logic        miss_r,
  output logic [1:0]  pio_address,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [31:0] pio_writedata
);

  localparam int FLASH_TICKS = 2 * FLASH_COUNT;
  localparam int FW = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_TICKS - 1);

  state_t            state_reg, state_next;
  logic [2:0]        pos_reg, pos_next;
  logic              dir_reg, dir_next;
  logic [LED_W-1:0]  pattern_reg, pattern_next;
  logic [FW-1:0]     flash_cnt_reg, flash_cnt_next;
  logic              miss_l_reg, miss_l_next;
  logic              miss_r_reg, miss_r_next;
  logic              busy_reg, busy_next;
  logic              pend_reg;
  logic              wr_reg;
  logic [LED_W-1:0]  wdata_reg;
  logic [LED_W-1:0]  ball_onehot;
  pat_op_t           pat_op;
  logic              tick;
  logic              tick_clear;
  logic              tick_enable;
  logic              write_strobe;

  // The counter restarts on every state change so each phase gets full-length steps.
  assign tick_enable = (state_reg != IDLE);
  assign tick_clear  = stop || (state_next != state_reg);

  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .clear  (tick_clear),
    .enable (tick_enable),
    .tick   (tick)
  );

  genvar gi;
  generate
    for (gi = 0; gi < LED_W; gi++) begin : g_ball
      assign ball_onehot[gi] = (pos_next == 3'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      pos_reg       <= '0;
      dir_reg       <= 1'b0;
      pattern_reg   <= '0;
      flash_cnt_reg <= '0;
      miss_l_reg    <= 1'b0;
      miss_r_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      pend_reg      <= 1'b1;
      wr_reg        <= 1'b0;
      wdata_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      pos_reg       <= pos_next;
      dir_reg       <= dir_next;
      pattern_reg   <= pattern_next;
      flash_cnt_reg <= flash_cnt_next;
      miss_l_reg    <= miss_l_next;
      miss_r_reg    <= miss_r_next;
      busy_reg      <= busy_next;
      pend_reg      <= (pattern_next != pattern_reg);
      wr_reg        <= pend_reg;
      wdata_reg     <= pattern_reg;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pos_next       = pos_reg;
    dir_next       = dir_reg;
    flash_cnt_next = flash_cnt_reg;
    miss_l_next    = 1'b0;
    miss_r_next    = 1'b0;
    pat_op         = PAT_HOLD;
    if (stop) begin
      state_next = IDLE;
      pat_op     = PAT_CLEAR;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_next = RUN;
            pos_next   = 3'd0;
            dir_next   = 1'b0;
            pat_op     = PAT_BALL;
          end
        end
        RUN: begin
          if (tick) begin
            if (pos_reg == 3'd7 && !dir_reg) begin
              if (paddle_r) begin
                dir_next = 1'b1;
                pos_next = 3'd6;
                pat_op   = PAT_BALL;
              end else begin
                miss_r_next    = 1'b1;
                state_next     = FLASH;
                flash_cnt_next = '0;
                pat_op         = PAT_ALL_ON;
              end
            end else if (pos_reg == 3'd0 && dir_reg) begin
              if (paddle_l) begin
                dir_next = 1'b0;
                pos_next = 3'd1;
                pat_op   = PAT_BALL;
              end else begin
                miss_l_next    = 1'b1;
                state_next     = FLASH;
                flash_cnt_next = '0;
                pat_op         = PAT_ALL_ON;
              end
            end else begin
              pos_next = dir_reg ? pos_reg - 3'd1 : pos_reg + 3'd1;
              pat_op   = PAT_BALL;
            end
          end
        end
        FLASH: begin
          // The last flash tick lands on the all-off phase, so going idle adds no write.
          if (tick) begin
            if (flash_cnt_reg == FLASH_LAST) begin
              state_next = IDLE;
              pat_op     = PAT_CLEAR;
            end else begin
              flash_cnt_next = flash_cnt_reg + FW'(1);
              pat_op         = PAT_TOGGLE;
            end
          end
        end
        default: begin
          state_next = IDLE;
          pat_op     = PAT_CLEAR;
        end
      endcase
    end
  end

  always_comb begin
    pattern_next = pattern_reg;
    case (pat_op)
      PAT_CLEAR:  pattern_next = '0;
      PAT_BALL:   pattern_next = ball_onehot;
      PAT_ALL_ON: pattern_next = PATTERN_ALL_ON;
      PAT_TOGGLE: pattern_next = ~pattern_reg;
      default:    pattern_next = pattern_reg;
    endcase
    busy_next    = (state_next != IDLE);
    // A strobe sharing its cycle with reset must never reach the PIO.
    write_strobe = wr_reg && !reset;
  end

  assign busy           = busy_reg;
  assign miss_l         = miss_l_reg;
  assign miss_r         = miss_r_reg;
  assign pio_address    = PIO_DATA_ADDR;
  assign pio_chipselect = write_strobe;
  assign pio_write_n    = !write_strobe;
  assign pio_writedata  = {{(32 - LED_W){1'b0}}, wdata_reg};

endmodule

// File: tb/tb_led_bounce_sequencer.sv
// Self-checking bench for led_bounce_sequencer with a behavioural ball/flash model.
// Inputs change on the falling edge; outputs are compared 1 ns later.
module tb_led_bounce_sequencer;

  localparam int TD = 4;
  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        paddle_l = 1'b0;
  logic        paddle_r = 1'b0;
  logic        busy, miss_l, miss_r;
  logic [1:0]  pio_address;
  logic        pio_chipselect, pio_write_n;
  logic [31:0] pio_writedata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  led_bounce_sequencer #(
    .TICK_DIV    (TD),
    .FLASH_COUNT (FC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .stop           (stop),
    .paddle_l       (paddle_l),
    .paddle_r       (paddle_r),
    .busy           (busy),
    .miss_l         (miss_l),
    .miss_r         (miss_r),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata)
  );

  // Model: mode 0 idle, 1 ball in play, 2 flashing. Ball is an integer position with a +1/-1 step.
  int         m_mode = 0, m_ball = 0, m_step = 1, m_phase = 0, m_flash = 0;
  logic [7:0] m_pat = 8'h00, m_sched_data = 8'h00, m_wdata = 8'h00;
  bit         m_sched = 1'b0, m_wr = 1'b0, m_busy = 1'b0, m_ml = 1'b0, m_mr = 1'b0;
  bit         ecs;
  logic [7:0] wq[$];
  int         cnt_ml, cnt_mr;

  task automatic model_edge();
    logic [7:0] old_pat;
    int  new_mode;
    bit  tick_now;
    if (reset) begin
      m_mode = 0; m_pat = 8'h00; m_phase = 0;
      m_wr = 1'b0; m_wdata = 8'h00; m_sched = 1'b1; m_sched_data = 8'h00;
      m_busy = 1'b0; m_ml = 1'b0; m_mr = 1'b0;
      return;
    end
    old_pat  = m_pat;
    m_ml     = 1'b0;
    m_mr     = 1'b0;
    new_mode = m_mode;
    tick_now = (m_mode != 0) && (m_phase == TD - 1);
    if (m_mode != 0) m_phase = (m_phase + 1) % TD;
    if (stop) begin
      new_mode = 0; m_pat = 8'h00; m_phase = 0;
    end else if (m_mode == 0) begin
      if (start) begin
        new_mode = 1; m_ball = 0; m_step = 1; m_pat = 8'h01; m_phase = 0;
      end
    end else if (m_mode == 1 && tick_now) begin
      if (m_ball == 7 && m_step == 1 && !paddle_r) begin
        m_mr = 1'b1; new_mode = 2; m_pat = 8'hFF; m_flash = 0; m_phase = 0;
      end else if (m_ball == 0 && m_step == -1 && !paddle_l) begin
        m_ml = 1'b1; new_mode = 2; m_pat = 8'hFF; m_flash = 0; m_phase = 0;
      end else begin
        if ((m_ball == 7 && m_step == 1) || (m_ball == 0 && m_step == -1)) m_step = -m_step;
        m_ball = m_ball + m_step;
        m_pat  = 8'(1 << m_ball);
      end
    end else if (m_mode == 2 && tick_now) begin
      m_flash = m_flash + 1;
      if (m_flash == 2 * FC) begin
        new_mode = 0; m_pat = 8'h00; m_phase = 0;
      end else begin
        m_pat = ~m_pat;
      end
    end
    m_mode       = new_mode;
    m_busy       = (new_mode != 0);
    m_wr         = m_sched;
    m_wdata      = m_sched_data;
    m_sched      = (m_pat != old_pat);
    m_sched_data = m_pat;
  endtask

  initial forever begin
    @(posedge clk);
    model_edge();
  end

  // Records observed writes and miss pulses; does not judge them.
  task automatic sample();
    if (pio_chipselect === 1'b1 && pio_write_n === 1'b0) wq.push_back(pio_writedata[7:0]);
    if (miss_l === 1'b1) cnt_ml++;
    if (miss_r === 1'b1) cnt_mr++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({pio_chipselect, pio_write_n, pio_address, pio_writedata, busy, miss_l, miss_r} !== {1'b0, 1'b1, 2'b00, 32'h0, 3'b000}) begin
      errors++;
      $display("FAIL reset_values got cs=%b wn=%b addr=%h data=%h busy=%b ml=%b mr=%b want cs=0 wn=1 addr=0 data=0 busy=0 ml=0 mr=0",
               pio_chipselect, pio_write_n, pio_address, pio_writedata, busy, miss_l, miss_r);
    end
    wq.delete();
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      reset = 1'b0;
      #1;
      ecs = m_wr && !reset;
      checks++;
      if ({pio_chipselect, pio_write_n, busy, miss_l, miss_r, pio_address} !== {ecs, !ecs, m_busy, m_ml, m_mr, 2'b00}) begin
        errors++;
        $display("FAIL reset_idle k=%0d cs/wn/busy/ml/mr/addr got=%b want=%b", k,
                 {pio_chipselect, pio_write_n, busy, miss_l, miss_r, pio_address}, {ecs, !ecs, m_busy, m_ml, m_mr, 2'b00});
      end
      if (ecs) begin
        checks++;
        if (pio_writedata !== {24'h0, m_wdata}) begin
          errors++;
          $display("FAIL reset_idle k=%0d wdata got=%h want=%h", k, pio_writedata, {24'h0, m_wdata});
        end
      end
      sample();
    end
    checks++;
    if (wq.size() != 1) begin
      errors++;
      $display("FAIL reset_write_count got=%0d want=1", wq.size());
    end else if (wq[0] !== 8'h00) begin
      errors++;
      $display("FAIL reset_write_value got=%h want=00", wq[0]);
    end
  endtask

  task automatic test_serve();
    logic [7:0] exp_seq[10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40, 8'h20};
    wq.delete();
    for (int k = 0; k < 39; k++) begin
      @(negedge clk);
      start    = (k == 0);
      paddle_r = 1'b1;
      paddle_l = 1'($urandom_range(0, 1));
      #1;
      ecs = m_wr && !reset;
      checks++;
      if ({pio_chipselect, pio_write_n, busy, miss_l, miss_r, pio_address} !== {ecs, !ecs, m_busy, m_ml, m_mr, 2'b00}) begin
        errors++;
        $display("FAIL serve k=%0d cs/wn/busy/ml/mr/addr got=%b want=%b", k,
                 {pio_chipselect, pio_write_n, busy, miss_l, miss_r, pio_address}, {ecs, !ecs, m_busy, m_ml, m_mr, 2'b00});
      end
      if (ecs) begin
        checks++;
        if (pio_writedata !== {24'h0, m_wdata}) begin
          errors++;
          $display("FAIL serve k=%0d wdata got=%h want=%h", k, pio_writedata, {24'h0, m_wdata});
        end
      end
      if (k >= 1) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL serve_busy k=%0d got=%b want=1", k, busy);
        end
      end
      sample();
    end
    checks++;
    if (wq.size() != 10) begin
      errors++;
      $display("FAIL serve_write_count got=%0d want=10", wq.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (wq[i] !== exp_seq[i]) begin
          errors++;
          $display("FAIL serve_seq idx=%0d got=%h want=%h", i, wq[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_return();
    logic [7:0] exp_seq[6] = '{8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    wq.delete();
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      paddle_l = 1'b1;
      paddle_r = 1'($urandom_range(0, 1));
      #1;
      ecs = m_wr && !reset;
      checks++;
      if ({pio_chipselect, pio_write_n, busy, miss_l, miss_r, pio_address} !== {ecs, !ecs, m_busy, m_ml, m_mr, 2'b00}) begin
        errors++;
        $display("FAIL return k=%0d cs/wn/busy/ml/mr/addr got=%b want=%b", k,
                 {pio_chipselect, pio_write_n, busy, miss_l, miss_r, pio_address}, {ecs, !ecs, m_busy, m_ml, m_mr, 2'b00});
      end
      if (ecs) begin
        checks++;
        if (pio_writedata !== {24'h0, m_wdata}) begin
          errors++;
          $display("FAIL return k=%0d wdata got=%h want=%h", k, pio_writedata, {24'h0, m_wdata});
        end
      end
      sample();
    end
    checks++;
    if (wq.size() != 6) begin
      errors++;
      $display("FAIL return_write_count got=%0d want=6", wq.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (wq[i] !== exp_seq[i]) begin
          errors++;
          $display("FAIL return_seq idx=%0d got=%h want=%h", i, wq[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_miss_r();
    logic [7:0] exp_seq[10] = '{8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'hFF, 8'h00, 8'hFF, 8'h00};
    wq.delete();
    cnt_ml = 0;
    cnt_mr = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      paddle_r = 1'b0;
      paddle_l = 1'($urandom_range(0, 1));
      #1;
      ecs = m_wr && !reset;
      checks++;
      if ({pio_chipselect, pio_write_n, busy, miss_l, miss_r, pio_address} !== {ecs, !ecs, m_busy, m_ml, m_mr, 2'b00}) begin
        errors++;
        $display("FAIL miss_r k=%0d cs/wn/busy/ml/mr/addr got=%b want=%b", k,
                 {pio_chipselect, pio_write_n, busy, miss_l, miss_r, pio_address}, {ecs, !ecs, m_busy, m_ml, m_mr, 2'b00});
      end
      if (ecs) begin
        checks++;
        if (pio_writedata !== {24'h0, m_wdata}) begin
          errors++;
          $display("FAIL miss_r k=%0d wdata got=%h want=%h", k, pio_writedata, {24'h0, m_wdata});
        end
      end
      sample();
    end
    checks++;
    if (cnt_mr != 1 || cnt_ml != 0) begin
      errors++;
      $display("FAIL miss_r_pulses got mr=%0d ml=%0d want mr=1 ml=0", cnt_mr, cnt_ml);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL miss_r_busy_end got=%b want=0", busy);
    end
    checks++;
    if (wq.size() != 10) begin
      errors++;
      $display("FAIL miss_r_write_count got=%0d want=10", wq.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (wq[i] !== exp_seq[i]) begin
          errors++;
          $display("FAIL miss_r_seq idx=%0d got=%h want=%h", i, wq[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_stop_start();
    int d;
    int zeros;
    d = int'($urandom_range(6, 20));
    for (int k = 0; k < d + 14 + 6; k++) begin
      @(negedge clk);
      start    = (k == 0) || (k == d) || (k == d + 14);
      stop     = (k == d);
      paddle_l = 1'($urandom_range(0, 1));
      paddle_r = 1'($urandom_range(0, 1));
      if (k == d || k == d + 14) wq.delete();
      #1;
      ecs = m_wr && !reset;
      checks++;
      if ({pio_chipselect, pio_write_n, busy, miss_l, miss_r, pio_address} !== {ecs, !ecs, m_busy, m_ml, m_mr, 2'b00}) begin
        errors++;
        $display("FAIL stop_start k=%0d cs/wn/busy/ml/mr/addr got=%b want=%b", k,
                 {pio_chipselect, pio_write_n, busy, miss_l, miss_r, pio_address}, {ecs, !ecs, m_busy, m_ml, m_mr, 2'b00});
      end
      if (ecs) begin
        checks++;
        if (pio_writedata !== {24'h0, m_wdata}) begin
          errors++;
          $display("FAIL stop_start k=%0d wdata got=%h want=%h", k, pio_writedata, {24'h0, m_wdata});
        end
      end
      sample();
      if (k == d + 13) begin
        zeros = 0;
        foreach (wq[i]) if (wq[i] === 8'h00) zeros++;
        checks++;
        if (wq.size() == 0 || wq[wq.size() - 1] !== 8'h00 || zeros != 1 || busy !== 1'b0) begin
          errors++;
          $display("FAIL stop_start_abort got writes=%0d zeros=%0d busy=%b want last=00 zeros=1 busy=0", wq.size(), zeros, busy);
        end
      end
    end
    checks++;
    if (wq.size() != 1 || wq[0] !== 8'h01) begin
      errors++;
      $display("FAIL stop_start_restart got writes=%0d first=%h want one write of 01", wq.size(), (wq.size() > 0) ? wq[0] : 8'hxx);
    end
  endtask

  task automatic test_reset_flash();
    for (int k = 0; k < 56; k++) begin
      @(negedge clk);
      stop     = (k == 0);
      start    = (k == 4);
      reset    = (k == 42);
      paddle_r = 1'b0;
      paddle_l = 1'($urandom_range(0, 1));
      if (k == 43) wq.delete();
      #1;
      ecs = m_wr && !reset;
      checks++;
      if ({pio_chipselect, pio_write_n, busy, miss_l, miss_r, pio_address} !== {ecs, !ecs, m_busy, m_ml, m_mr, 2'b00}) begin
        errors++;
        $display("FAIL reset_flash k=%0d cs/wn/busy/ml/mr/addr got=%b want=%b", k,
                 {pio_chipselect, pio_write_n, busy, miss_l, miss_r, pio_address}, {ecs, !ecs, m_busy, m_ml, m_mr, 2'b00});
      end
      if (ecs) begin
        checks++;
        if (pio_writedata !== {24'h0, m_wdata}) begin
          errors++;
          $display("FAIL reset_flash k=%0d wdata got=%h want=%h", k, pio_writedata, {24'h0, m_wdata});
        end
      end
      if (k == 42) begin
        checks++;
        if (pio_chipselect !== 1'b0 || pio_write_n !== 1'b1 || m_wr !== 1'b1) begin
          errors++;
          $display("FAIL reset_flash_strobe got cs=%b wn=%b pending=%b want cs=0 wn=1 pending=1", pio_chipselect, pio_write_n, m_wr);
        end
      end
      if (k == 43) begin
        checks++;
        if ({pio_chipselect, pio_write_n, busy, miss_l, miss_r, pio_writedata} !== {1'b0, 1'b1, 3'b000, 32'h0}) begin
          errors++;
          $display("FAIL reset_flash_values got cs=%b wn=%b busy=%b ml=%b mr=%b data=%h want 0/1/0/0/0/0",
                   pio_chipselect, pio_write_n, busy, miss_l, miss_r, pio_writedata);
        end
      end
      sample();
    end
    checks++;
    if (wq.size() != 1 || wq[0] !== 8'h00) begin
      errors++;
      $display("FAIL reset_flash_post_write got writes=%0d want one write of 00", wq.size());
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      start    = ($urandom_range(0, 7) == 0);
      stop     = ($urandom_range(0, 39) == 0);
      reset    = ($urandom_range(0, 299) == 0);
      paddle_l = ($urandom_range(0, 3) != 0);
      paddle_r = ($urandom_range(0, 3) != 0);
      #1;
      ecs = m_wr && !reset;
      checks++;
      if ({pio_chipselect, pio_write_n, busy, miss_l, miss_r, pio_address} !== {ecs, !ecs, m_busy, m_ml, m_mr, 2'b00}) begin
        errors++;
        $display("FAIL random k=%0d cs/wn/busy/ml/mr/addr got=%b want=%b", k,
                 {pio_chipselect, pio_write_n, busy, miss_l, miss_r, pio_address}, {ecs, !ecs, m_busy, m_ml, m_mr, 2'b00});
      end
      if (ecs) begin
        checks++;
        if (pio_writedata !== {24'h0, m_wdata}) begin
          errors++;
          $display("FAIL random k=%0d wdata got=%h want=%h", k, pio_writedata, {24'h0, m_wdata});
        end
      end
    end
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    $display("test_reset done: checks=%0d errors=%0d", checks, errors);
    test_serve();
    $display("test_serve done: checks=%0d errors=%0d", checks, errors);
    test_return();
    $display("test_return done: checks=%0d errors=%0d", checks, errors);
    test_miss_r();
    $display("test_miss_r done: checks=%0d errors=%0d", checks, errors);
    test_stop_start();
    $display("test_stop_start done: checks=%0d errors=%0d", checks, errors);
    test_reset_flash();
    $display("test_reset_flash done: checks=%0d errors=%0d", checks, errors);
    test_random();
    $display("test_random done: checks=%0d errors=%0d", checks, errors);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
